demux_12_striper: RTL

- 1:2 demultiplexer that splits one word stream into two lanes, A and B. Words alternate between the lanes.
- Inverse of the 2:1 lane mux: it rebuilds the A/B lane pair that the mux's S select interleaves onto one line.
- Registered, single clock domain. Sits between the serial-side datapath and the two-lane logic.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_12_striper_lane_reg.sv | 26 ++
 rtl/demux_12_striper.sv | 92 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 lane striper and its 2:1 mux counterpart.
package demux_pkg;

  // Lane pointer encoding: the FSM state bit doubles as the select output.
  localparam logic S_WAIT_A = 1'b0;
  localparam logic S_WAIT_B = 1'b1;

  // Lane indices used to address per-lane arrays.
  localparam int LANE_A = 0;
  localparam int LANE_B = 1;

  typedef enum logic {
    WAIT_A = S_WAIT_A,
    WAIT_B = S_WAIT_B
  } state_e;

endpackage

// File: rtl/demux_12_striper_lane_reg.sv
// One output lane: load-enable word register with a one-cycle update pulse.
module lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset_L,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             pulse
);

  // Capture the word when loaded and flag the update for exactly one cycle.
  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      q     <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= load;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/demux_12_striper.sv
// 1:2 demultiplexer: alternates incoming words onto lanes A and B and
// reports coherent pairs, including pairs closed early by flush.
module demux_12_striper
  import demux_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int unsigned FLUSH_FILL = 0
) (
  input  logic             clk,
  input  logic             Reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             flush,
  output logic [WIDTH-1:0] out_A,
  output logic [WIDTH-1:0] out_B,
  output logic             valid_A,
  output logic             valid_B,
  output logic             pair_valid,
  output logic             odd_flag,
  output logic             sel
);

  localparam logic [WIDTH-1:0] FILL_W = WIDTH'(FLUSH_FILL);

  state_e state_q;
  logic   pair_valid_q;
  logic   odd_flag_q;

  logic accept_a;
  logic accept_b;
  logic flush_b;

  logic [1:0]       lane_load;
  logic [1:0]       lane_pulse;
  logic [WIDTH-1:0] lane_d [2];
  logic [WIDTH-1:0] lane_q [2];

  // A valid word always wins over flush; flush only matters with a half-pair open.
  assign accept_a = (state_q == WAIT_A) && valid_in;
  assign accept_b = (state_q == WAIT_B) && valid_in;
  assign flush_b  = (state_q == WAIT_B) && !valid_in && flush;

  assign lane_load[LANE_A] = accept_a;
  assign lane_load[LANE_B] = accept_b || flush_b;

  // Lane B takes the fill value only on a flush, so data_in is never
  // looked at unless valid_in is high.
  assign lane_d[LANE_A] = data_in;
  assign lane_d[LANE_B] = valid_in ? data_in : FILL_W;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      lane_reg #(
        .WIDTH (WIDTH)
      ) u_lane (
        .clk     (clk),
        .Reset_L (Reset_L),
        .load    (lane_load[gi]),
        .d       (lane_d[gi]),
        .q       (lane_q[gi]),
        .pulse   (lane_pulse[gi])
      );
    end
  endgenerate

  // Lane pointer FSM plus the registered pair-complete and flush-completed flags.
  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q      <= WAIT_A;
      pair_valid_q <= 1'b0;
      odd_flag_q   <= 1'b0;
    end else begin
      pair_valid_q <= accept_b || flush_b;
      odd_flag_q   <= flush_b;
      case (state_q)
        WAIT_A: if (valid_in) state_q <= WAIT_B;
        WAIT_B: if (valid_in || flush) state_q <= WAIT_A;
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign out_A      = lane_q[LANE_A];
  assign out_B      = lane_q[LANE_B];
  assign valid_A    = lane_pulse[LANE_A];
  // A flush rewrites lane B but is not a real lane-B word.
  assign valid_B    = lane_pulse[LANE_B] && !odd_flag_q;
  assign pair_valid = pair_valid_q;
  assign odd_flag   = odd_flag_q;
  assign sel        = state_q;

endmodule
